uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
UART receiver, the counterpart of the team's uart_tx. Shares the same cfg_* register fields, and the same frame format: start, 5-8 data bits LSB first, optional parity, 1-2 stop bits.
- Oversamples rx_i with a per-bit baud counter.
- Delivers each received byte on a valid/ready handshake toward the register/FIFO layer.
- Reports parity, framing and overrun errors alongside the data.

Parameters:
None; the divider width is fixed at 16 bits, the same as the TX side.

Ports:
clk_i  in  1  clock
rst_n_i  in  1  reset; asynchronous, active-low
rx_i  in  1  serial line; asynchronous to clk_i, idles high
busy_o  out  1  high while the FSM is not IDLE
cfg_en_i  in  1  receiver enable
cfg_div_i  in  16  bit period P = cfg_div_i+1 clocks; legal minimum 3
cfg_parity_en_i  in  1  parity bit present
cfg_parity_sel_i  in  2  00 expect ~XOR(data), 01 expect XOR(data), 10 expect 0, 11 expect 1
cfg_bits_i  in  2  data bits: 00=5, 01=6, 10=7, 11=8
cfg_stop_bits_i  in  1  0 = one stop bit, 1 = two stop bits
rx_data_o  out  8  received byte, right-aligned, unused MSBs zero
rx_valid_o  out  1  rx_data_o and err_* are valid
rx_ready_i  in  1  consumer accepts
err_parity_o  out  1  parity mismatch, qualified by rx_valid_o
err_frame_o  out  1  a stop bit sampled 0, qualified by rx_valid_o
err_overrun_o  out  1  one-cycle pulse when a completed frame is dropped

Behaviour:
- Reset values: all outputs 0, rx_data_o = 0, FSM IDLE, baud counter 0, synchronizer flops 1.
- Input path:
  - rx_i passes through a 2-flop synchronizer, reset to 1.
  - Edge detect uses the synced value and one delayed copy.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2.
- IDLE:
  - Entered when cfg_en_i is high and a 1->0 transition is seen on the synced line.
  - On that transition: go to START and load the counter.
- START:
  - Wait floor(cfg_div_i/2)+1 clocks (mid-bit), then sample.
  - Sample 1: false start, return to IDLE, no error, no output.
  - Sample 0: go to DATA.
- DATA:
  - Sample every P clocks and shift into a shift register, LSB first.
  - Keep a running XOR of the sampled bits.
  - After the Nth bit (N from cfg_bits_i): go to PARITY if cfg_parity_en_i, else STOP1.
- PARITY: sample after P clocks; compare against the expected bit per cfg_parity_sel_i; latch the mismatch.
- STOP1:
  - Sample after P clocks; a 0 sets the frame error.
  - If cfg_stop_bits_i, go to STOP2.
  - Otherwise complete the frame and return to IDLE immediately, at mid stop bit, so back-to-back start edges are caught.
- STOP2: sample after P clocks; a 0 sets the frame error; complete the frame; return to IDLE.
- Frame completion, in the cycle after the final stop sample:
  - If rx_valid_o = 0: load rx_data_o, err_parity_o and err_frame_o, and set rx_valid_o.
  - If rx_valid_o = 1 and rx_ready_i = 0: the new frame is discarded, the held data is unchanged, and err_overrun_o pulses for 1 cycle.
  - If rx_valid_o = 1 and rx_ready_i = 1 in the same cycle: the handshake completes and the new frame loads. No overrun.
- Output handshake:
  - A frame with errors is still delivered; the err_* flags are sampled with the data.
  - rx_valid_o holds until rx_valid_o & rx_ready_i, then clears the next cycle unless a new frame loads in the same cycle.
- Configuration changes:
  - cfg_* must be static while busy_o = 1; behaviour otherwise is undefined but must not lock up.
  - cfg_en_i low forces IDLE next cycle, clears the baud counter and clears rx_valid_o. rx_data_o is retained.
- Reset asserted mid-frame: immediate return to reset values; no partial frame is delivered.
- Baud counter:
  - 16-bit; counts up to its target, then reloads to 0 and asserts a one-cycle sample strobe.
  - Does not count in IDLE.

Optional Feature:
UART_RX_FILTER_EN:
- Defined: each bit sample (start, data, parity, stop) is the 2-of-3 majority of the synced line at mid-1, mid and mid+1 clocks. Legal minimum cfg_div_i rises to 4.
- Undefined: a single synced sample is taken at mid-bit. The filter logic and its sample history are absent.

Decomposition:
- uart_pkg holds:
  - rx FSM enum;
  - parity-select constants (UART_PARITY_ODD=2'b00, EVEN=2'b01, ZERO=2'b10, ONE=2'b11);
  - data-bits encoding constants;
  - a function mapping cfg_bits_i to the last bit index.
- One sub-module, uart_rx_sync: 2-flop synchronizer, falling-edge detect, and the optional majority filter under UART_RX_FILTER_EN.

Test Plan:
- cfg_div_i=15, 8N1, frame 0xA5 -> rx_valid_o=1 with rx_data_o=0xA5 and no errors, about 9.5 bit periods (~152 clocks plus sync latency) after the start edge.
- 7E1: cfg_bits_i=10, parity_en=1, sel=01, send 0x55 with the parity bit inverted -> rx_data_o=0x55, err_parity_o=1. Sending the correct parity -> err_parity_o=0.
- 5N2, cfg_stop_bits_i=1: send 0x1F with the second stop bit forced 0 -> rx_data_o=0x1F, err_frame_o=1.
- rx_i low pulse of 4 clocks with cfg_div_i=15 -> false start, FSM returns to IDLE, rx_valid_o stays 0; a proper following frame 0x3C is received correctly.
- Two back-to-back frames 0x11 then 0x22 with rx_ready_i=0 -> rx_data_o stays 0x11 and err_overrun_o pulses once. Then rx_ready_i=1 -> 0x11 is accepted and rx_valid_o drops.
- cfg_en_i deasserted mid-DATA, then a full frame 0x81 is sent after re-enable -> no output from the aborted frame; 0x81 is delivered cleanly, busy_o=0 between frames.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART receive types: FSM states, parity/data-bit encodings, bit-count helper.
// UART_RX_FILTER_EN moves the mid-bit strobe one clock later so the majority window is centred.
package uart_pkg;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP1,
    RX_STOP2
  } rx_state_e;

  localparam logic [1:0] UART_PARITY_ODD  = 2'b00;
  localparam logic [1:0] UART_PARITY_EVEN = 2'b01;
  localparam logic [1:0] UART_PARITY_ZERO = 2'b10;
  localparam logic [1:0] UART_PARITY_ONE  = 2'b11;

  localparam logic [1:0] UART_BITS_5 = 2'b00;
  localparam logic [1:0] UART_BITS_6 = 2'b01;
  localparam logic [1:0] UART_BITS_7 = 2'b10;
  localparam logic [1:0] UART_BITS_8 = 2'b11;

`ifdef UART_RX_FILTER_EN
  localparam logic [15:0] UART_RX_MID_ADJ = 16'd1;
`else
  localparam logic [15:0] UART_RX_MID_ADJ = 16'd0;
`endif

  function automatic logic [2:0] last_bit_idx(input logic [1:0] bits);
    return 3'd4 + {1'b0, bits};
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// rx line synchronizer (2 flops, reset high), falling-edge detect and bit sampler; 2-cycle latency, no backpressure.
// UART_RX_FILTER_EN: sample is the 2-of-3 majority of the synced line over the last three clocks.
module uart_rx_sync (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic rx_i,
  output logic fall_o,
  output logic samp_o
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic dly_q, dly_d;

  always_comb begin
    sync1_d = rx_i;
    sync2_d = sync1_q;
    dly_d   = sync2_q;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      dly_q   <= 1'b1;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      dly_q   <= dly_d;
    end
  end

  assign fall_o = dly_q & ~sync2_q;

`ifdef UART_RX_FILTER_EN
  logic dly2_q, dly2_d;

  always_comb dly2_d = dly_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) dly2_q <= 1'b1;
    else          dly2_q <= dly2_d;
  end

  assign samp_o = (sync2_q & dly_q) | (sync2_q & dly2_q) | (dly_q & dly2_q);
`else
  assign samp_o = sync2_q;
`endif

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 5-8 data bits, optional parity, 1-2 stops; byte valid the cycle after the last stop sample.
// Held frame waits for rx_ready_i; a frame completing while still held is dropped with an overrun pulse.
module uart_rx
  import uart_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        rx_i,
  output logic        busy_o,
  input  logic        cfg_en_i,
  input  logic [15:0] cfg_div_i,
  input  logic        cfg_parity_en_i,
  input  logic [1:0]  cfg_parity_sel_i,
  input  logic [1:0]  cfg_bits_i,
  input  logic        cfg_stop_bits_i,
  output logic [7:0]  rx_data_o,
  output logic        rx_valid_o,
  input  logic        rx_ready_i,
  output logic        err_parity_o,
  output logic        err_frame_o,
  output logic        err_overrun_o
);

  logic fall, samp;

  uart_rx_sync u_sync (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .rx_i    (rx_i),
    .fall_o  (fall),
    .samp_o  (samp)
  );

  rx_state_e   state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  idx_q, idx_d;
  logic        par_q, par_d;
  logic        perr_q, perr_d;
  logic        ferr_q, ferr_d;
  logic        done_q, done_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        eperr_q, eperr_d;
  logic        eferr_q, eferr_d;
  logic        ovr_q, ovr_d;

  logic [15:0] target;
  logic        strobe;
  logic        exp_par;

  always_comb begin
    target = (state_q == RX_START) ? ({1'b0, cfg_div_i[15:1]} + UART_RX_MID_ADJ) : cfg_div_i;
    strobe = (state_q != RX_IDLE) && (cnt_q == target);
    case (cfg_parity_sel_i)
      UART_PARITY_ODD:  exp_par = ~par_q;
      UART_PARITY_EVEN: exp_par = par_q;
      UART_PARITY_ZERO: exp_par = 1'b0;
      default:          exp_par = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = strobe ? 16'd0 : cnt_q + 16'd1;
    shift_d = shift_q;
    idx_d   = idx_q;
    par_d   = par_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    done_d  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        cnt_d = 16'd0;
        if (fall) begin
          state_d = RX_START;
          idx_d   = 3'd0;
          par_d   = 1'b0;
          perr_d  = 1'b0;
          ferr_d  = 1'b0;
        end
      end
      RX_START: if (strobe) state_d = samp ? RX_IDLE : RX_DATA;
      RX_DATA: if (strobe) begin
        // Shift in from the top; the byte is right-aligned at completion.
        shift_d = {samp, shift_q[7:1]};
        par_d   = par_q ^ samp;
        idx_d   = idx_q + 3'd1;
        if (idx_q == last_bit_idx(cfg_bits_i))
          state_d = cfg_parity_en_i ? RX_PARITY : RX_STOP1;
      end
      RX_PARITY: if (strobe) begin
        perr_d  = (samp != exp_par);
        state_d = RX_STOP1;
      end
      RX_STOP1: if (strobe) begin
        if (!samp) ferr_d = 1'b1;
        if (cfg_stop_bits_i) begin
          state_d = RX_STOP2;
        end else begin
          state_d = RX_IDLE;
          done_d  = 1'b1;
        end
      end
      RX_STOP2: if (strobe) begin
        if (!samp) ferr_d = 1'b1;
        state_d = RX_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = RX_IDLE;
    endcase
    if (!cfg_en_i) begin
      state_d = RX_IDLE;
      cnt_d   = 16'd0;
      done_d  = 1'b0;
    end
  end

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    eperr_d = eperr_q;
    eferr_d = eferr_q;
    ovr_d   = 1'b0;
    if (!cfg_en_i) begin
      valid_d = 1'b0;
    end else begin
      if (valid_q && rx_ready_i) valid_d = 1'b0;
      if (done_q) begin
        if (!valid_q || rx_ready_i) begin
          data_d  = shift_q >> (3'd7 - last_bit_idx(cfg_bits_i));
          valid_d = 1'b1;
          eperr_d = perr_q;
          eferr_d = ferr_q;
        end else begin
          ovr_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= RX_IDLE;
      cnt_q   <= 16'd0;
      shift_q <= 8'd0;
      idx_q   <= 3'd0;
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      done_q  <= 1'b0;
      data_q  <= 8'd0;
      valid_q <= 1'b0;
      eperr_q <= 1'b0;
      eferr_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      par_q   <= par_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      done_q  <= done_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      eperr_q <= eperr_d;
      eferr_q <= eferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign busy_o        = (state_q != RX_IDLE);
  assign rx_data_o     = data_q;
  assign rx_valid_o    = valid_q;
  assign err_parity_o  = eperr_q;
  assign err_frame_o   = eferr_q;
  assign err_overrun_o = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at cfg_div_i=15 (16 clocks per bit).
module tb_uart_rx;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        rx_i = 1'b1;
  logic        busy_o;
  logic        cfg_en_i = 1'b0;
  logic [15:0] cfg_div_i = 16'd15;
  logic        cfg_parity_en_i = 1'b0;
  logic [1:0]  cfg_parity_sel_i = 2'b00;
  logic [1:0]  cfg_bits_i = 2'b11;
  logic        cfg_stop_bits_i = 1'b0;
  logic [7:0]  rx_data_o;
  logic        rx_valid_o;
  logic        rx_ready_i = 1'b0;
  logic        err_parity_o;
  logic        err_frame_o;
  logic        err_overrun_o;

  localparam int P = 16;

  int n_pass = 0;
  int n_total = 0;
  int ovr_cnt = 0;
  int ovr0;

  uart_rx dut (
    .clk_i            (clk_i),
    .rst_n_i          (rst_n_i),
    .rx_i             (rx_i),
    .busy_o           (busy_o),
    .cfg_en_i         (cfg_en_i),
    .cfg_div_i        (cfg_div_i),
    .cfg_parity_en_i  (cfg_parity_en_i),
    .cfg_parity_sel_i (cfg_parity_sel_i),
    .cfg_bits_i       (cfg_bits_i),
    .cfg_stop_bits_i  (cfg_stop_bits_i),
    .rx_data_o        (rx_data_o),
    .rx_valid_o       (rx_valid_o),
    .rx_ready_i       (rx_ready_i),
    .err_parity_o     (err_parity_o),
    .err_frame_o      (err_frame_o),
    .err_overrun_o    (err_overrun_o)
  );

  always #5 clk_i = ~clk_i;

  always @(negedge clk_i) if (rst_n_i && err_overrun_o) ovr_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic drive_bit(input logic b);
    rx_i = b;
    repeat (P) @(posedge clk_i);
  endtask

  // par / s2 < 0 means the bit is absent from the frame
  task automatic send_frame(input logic [7:0] d, input int nbits, input int par,
                            input logic s1, input int s2);
    drive_bit(1'b0);
    for (int i = 0; i < nbits; i++) drive_bit(d[i]);
    if (par >= 0) drive_bit(par[0]);
    drive_bit(s1);
    if (s2 >= 0) drive_bit(s2[0]);
    rx_i = 1'b1;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    @(negedge clk_i);
    while (!rx_valid_o && n < 64) begin
      @(negedge clk_i);
      n++;
    end
    check(tag, {31'd0, rx_valid_o}, 32'd1);
  endtask

  task automatic accept(input string tag);
    @(negedge clk_i);
    rx_ready_i = 1'b1;
    @(posedge clk_i);
    #1 rx_ready_i = 1'b0;
    @(negedge clk_i);
    check(tag, {31'd0, rx_valid_o}, 32'd0);
  endtask

  task automatic set_cfg(input logic [1:0] bits, input logic pen, input logic [1:0] psel,
                         input logic stop2);
    cfg_bits_i       = bits;
    cfg_parity_en_i  = pen;
    cfg_parity_sel_i = psel;
    cfg_stop_bits_i  = stop2;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1);
  end

  initial begin
    repeat (5) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_valid", {31'd0, rx_valid_o}, 32'd0);
    rst_n_i  = 1'b1;
    cfg_en_i = 1'b1;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_data", {24'd0, rx_data_o}, 32'h00);
    check("rst_perr", {31'd0, err_parity_o}, 32'd0);
    check("rst_ferr", {31'd0, err_frame_o}, 32'd0);
    check("rst_ovr",  {31'd0, err_overrun_o}, 32'd0);

    // 8N1 0xA5
    set_cfg(2'b11, 1'b0, 2'b00, 1'b0);
    @(posedge clk_i);
    send_frame(8'hA5, 8, -1, 1'b1, -1);
    wait_valid("a5_vld");
    check("a5_data", {24'd0, rx_data_o}, 32'hA5);
    check("a5_perr", {31'd0, err_parity_o}, 32'd0);
    check("a5_ferr", {31'd0, err_frame_o}, 32'd0);
    accept("a5_acc");

    // 7E1 0x55: four ones -> even-select parity bit is 0; send 1 first
    set_cfg(2'b10, 1'b1, 2'b01, 1'b0);
    @(posedge clk_i);
    send_frame(8'h55, 7, 1, 1'b1, -1);
    wait_valid("7e1_bad_vld");
    check("7e1_bad_data", {24'd0, rx_data_o}, 32'h55);
    check("7e1_bad_perr", {31'd0, err_parity_o}, 32'd1);
    check("7e1_bad_ferr", {31'd0, err_frame_o}, 32'd0);
    accept("7e1_bad_acc");
    @(posedge clk_i);
    send_frame(8'h55, 7, 0, 1'b1, -1);
    wait_valid("7e1_ok_vld");
    check("7e1_ok_data", {24'd0, rx_data_o}, 32'h55);
    check("7e1_ok_perr", {31'd0, err_parity_o}, 32'd0);
    accept("7e1_ok_acc");

    // 5N2 0x1F with second stop bit 0
    set_cfg(2'b00, 1'b0, 2'b00, 1'b1);
    @(posedge clk_i);
    send_frame(8'h1F, 5, -1, 1'b1, 0);
    wait_valid("5n2_vld");
    check("5n2_data", {24'd0, rx_data_o}, 32'h1F);
    check("5n2_ferr", {31'd0, err_frame_o}, 32'd1);
    check("5n2_perr", {31'd0, err_parity_o}, 32'd0);
    accept("5n2_acc");

    // False start: 4-clock low glitch, then a real 8N1 frame 0x3C
    set_cfg(2'b11, 1'b0, 2'b00, 1'b0);
    @(posedge clk_i);
    rx_i = 1'b0;
    repeat (4) @(posedge clk_i);
    rx_i = 1'b1;
    @(negedge clk_i);
    check("fs_busy_hi", {31'd0, busy_o}, 32'd1);
    repeat (2 * P) @(posedge clk_i);
    @(negedge clk_i);
    check("fs_busy_lo", {31'd0, busy_o}, 32'd0);
    check("fs_valid", {31'd0, rx_valid_o}, 32'd0);
    @(posedge clk_i);
    send_frame(8'h3C, 8, -1, 1'b1, -1);
    wait_valid("3c_vld");
    check("3c_data", {24'd0, rx_data_o}, 32'h3C);
    accept("3c_acc");

    // Overrun: 0x11 then 0x22 back-to-back with no ready
    ovr0 = ovr_cnt;
    @(posedge clk_i);
    send_frame(8'h11, 8, -1, 1'b1, -1);
    send_frame(8'h22, 8, -1, 1'b1, -1);
    repeat (4) @(posedge clk_i);
    @(negedge clk_i);
    check("ovr_valid", {31'd0, rx_valid_o}, 32'd1);
    check("ovr_data", {24'd0, rx_data_o}, 32'h11);
    check("ovr_pulses", ovr_cnt - ovr0, 32'd1);
    accept("ovr_acc");
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("ovr_stays_lo", {31'd0, rx_valid_o}, 32'd0);

    // Disable mid-DATA, then re-enable and receive 0x81
    @(posedge clk_i);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b0);
    @(negedge clk_i);
    check("en_busy_mid", {31'd0, busy_o}, 32'd1);
    cfg_en_i = 1'b0;
    @(posedge clk_i);
    @(negedge clk_i);
    check("en_busy_off", {31'd0, busy_o}, 32'd0);
    rx_i = 1'b1;
    repeat (2 * P) @(posedge clk_i);
    cfg_en_i = 1'b1;
    repeat (P) @(posedge clk_i);
    @(negedge clk_i);
    check("en_busy_idle", {31'd0, busy_o}, 32'd0);
    check("en_no_output", {31'd0, rx_valid_o}, 32'd0);
    @(posedge clk_i);
    send_frame(8'h81, 8, -1, 1'b1, -1);
    wait_valid("81_vld");
    check("81_data", {24'd0, rx_data_o}, 32'h81);
    check("81_perr", {31'd0, err_parity_o}, 32'd0);
    check("81_ferr", {31'd0, err_frame_o}, 32'd0);
    accept("81_acc");
    @(negedge clk_i);
    check("81_busy_after", {31'd0, busy_o}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
